// File: rtl/crossbar_4x4.sv
// crossbar_4x4 - 4-master x 4-slave req/ack interconnect.
//
// Purpose:
//   Routes each master request to the slave selected by addr[ADDR_W-1:ADDR_W-2].
//   Each slave has its own round-robin arbiter with a grant lock, so a grant
//   holds until that slave acks. Request and ack paths are combinational.
//   Read data returns one cycle after a read ack, steered by a registered
//   per-slave source tag.
//
// Ports:
//   clk, reset_n                   clock, async active-low reset
//   master_<i>_req/addr/cmd/wdata  master request in (i = 1..4), cmd 0=rd 1=wr
//   master_<i>_ack/rdata           ack out (same cycle), read data out (+1 cycle)
//   slave_<j>_req/addr/cmd/wdata   forwarded request out (j = 1..4)
//   slave_<j>_ack/rdata            slave ack in, slave read data in (+1 cycle)
module crossbar_4x4 #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              master_1_req,
  input  logic [ADDR_W-1:0] master_1_addr,
  input  logic              master_1_cmd,
  input  logic [DATA_W-1:0] master_1_wdata,
  output logic              master_1_ack,
  output logic [DATA_W-1:0] master_1_rdata,
  input  logic              master_2_req,
  input  logic [ADDR_W-1:0] master_2_addr,
  input  logic              master_2_cmd,
  input  logic [DATA_W-1:0] master_2_wdata,
  output logic              master_2_ack,
  output logic [DATA_W-1:0] master_2_rdata,
  input  logic              master_3_req,
  input  logic [ADDR_W-1:0] master_3_addr,
  input  logic              master_3_cmd,
  input  logic [DATA_W-1:0] master_3_wdata,
  output logic              master_3_ack,
  output logic [DATA_W-1:0] master_3_rdata,
  input  logic              master_4_req,
  input  logic [ADDR_W-1:0] master_4_addr,
  input  logic              master_4_cmd,
  input  logic [DATA_W-1:0] master_4_wdata,
  output logic              master_4_ack,
  output logic [DATA_W-1:0] master_4_rdata,
  output logic              slave_1_req,
  output logic [ADDR_W-1:0] slave_1_addr,
  output logic              slave_1_cmd,
  output logic [DATA_W-1:0] slave_1_wdata,
  input  logic              slave_1_ack,
  input  logic [DATA_W-1:0] slave_1_rdata,
  output logic              slave_2_req,
  output logic [ADDR_W-1:0] slave_2_addr,
  output logic              slave_2_cmd,
  output logic [DATA_W-1:0] slave_2_wdata,
  input  logic              slave_2_ack,
  input  logic [DATA_W-1:0] slave_2_rdata,
  output logic              slave_3_req,
  output logic [ADDR_W-1:0] slave_3_addr,
  output logic              slave_3_cmd,
  output logic [DATA_W-1:0] slave_3_wdata,
  input  logic              slave_3_ack,
  input  logic [DATA_W-1:0] slave_3_rdata,
  output logic              slave_4_req,
  output logic [ADDR_W-1:0] slave_4_addr,
  output logic              slave_4_cmd,
  output logic [DATA_W-1:0] slave_4_wdata,
  input  logic              slave_4_ack,
  input  logic [DATA_W-1:0] slave_4_rdata
);

  logic [3:0]        w_m_req;
  logic [ADDR_W-1:0] w_m_addr  [4];
  logic [3:0]        w_m_cmd;
  logic [DATA_W-1:0] w_m_wdata [4];
  logic [3:0]        w_m_ack;
  logic [DATA_W-1:0] w_m_rdata [4];
  logic [3:0]        w_s_ack;
  logic [DATA_W-1:0] w_s_rdata [4];
  logic [3:0]        w_s_req;
  logic [ADDR_W-1:0] w_s_addr  [4];
  logic [3:0]        w_s_cmd;
  logic [DATA_W-1:0] w_s_wdata [4];

  logic [3:0]        w_req_to  [4];  // [slave][master]
  logic [3:0]        w_gnt_vld;
  logic [1:0]        w_gnt     [4];

  logic [1:0]        r_ptr     [4];
  logic [3:0]        r_locked;
  logic [1:0]        r_owner   [4];
  logic [3:0]        r_rd_pend;
  logic [1:0]        r_rd_src  [4];

  always_comb begin
    w_m_req      = {master_4_req, master_3_req, master_2_req, master_1_req};
    w_m_cmd      = {master_4_cmd, master_3_cmd, master_2_cmd, master_1_cmd};
    w_s_ack      = {slave_4_ack, slave_3_ack, slave_2_ack, slave_1_ack};
    w_m_addr[0]  = master_1_addr;   w_m_addr[1]  = master_2_addr;
    w_m_addr[2]  = master_3_addr;   w_m_addr[3]  = master_4_addr;
    w_m_wdata[0] = master_1_wdata;  w_m_wdata[1] = master_2_wdata;
    w_m_wdata[2] = master_3_wdata;  w_m_wdata[3] = master_4_wdata;
    w_s_rdata[0] = slave_1_rdata;   w_s_rdata[1] = slave_2_rdata;
    w_s_rdata[2] = slave_3_rdata;   w_s_rdata[3] = slave_4_rdata;
  end

  // Address decode and per-slave arbitration.
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      w_req_to[j] = '0;
      for (int m = 0; m < 4; m++)
        w_req_to[j][m] = w_m_req[m] && (w_m_addr[m][ADDR_W-1 -: 2] == 2'(j));
    end
    for (int j = 0; j < 4; j++) begin
      w_gnt_vld[j] = 1'b0;
      w_gnt[j]     = r_ptr[j];
      // A held lock only counts while its owner is still asking; otherwise
      // fall back to round robin so a withdrawn request cannot stall the slave.
      if (r_locked[j] && w_req_to[j][r_owner[j]]) begin
        w_gnt_vld[j] = 1'b1;
        w_gnt[j]     = r_owner[j];
      end else begin
        // Walk from lowest priority to highest so the last hit wins.
        for (int k = 3; k >= 0; k--) begin
          if (w_req_to[j][r_ptr[j] + 2'(k)]) begin
            w_gnt_vld[j] = 1'b1;
            w_gnt[j]     = r_ptr[j] + 2'(k);
          end
        end
      end
    end
  end

  // Request forwarding, ack return and read-data steering; all forced low in reset.
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      w_s_req[j]   = reset_n && w_gnt_vld[j];
      w_s_addr[j]  = w_s_req[j] ? w_m_addr[w_gnt[j]]  : '0;
      w_s_cmd[j]   = w_s_req[j] ? w_m_cmd[w_gnt[j]]   : 1'b0;
      w_s_wdata[j] = w_s_req[j] ? w_m_wdata[w_gnt[j]] : '0;
    end
    for (int m = 0; m < 4; m++) begin
      w_m_ack[m]   = 1'b0;
      w_m_rdata[m] = '0;
      for (int j = 0; j < 4; j++) begin
        if (w_s_req[j] && w_s_ack[j] && (w_gnt[j] == 2'(m)))
          w_m_ack[m] = 1'b1;
        if (reset_n && r_rd_pend[j] && (r_rd_src[j] == 2'(m)))
          w_m_rdata[m] = w_m_rdata[m] | w_s_rdata[j];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_locked  <= '0;
      r_rd_pend <= '0;
      for (int j = 0; j < 4; j++) begin
        r_ptr[j]    <= 2'd0;
        r_owner[j]  <= 2'd0;
        r_rd_src[j] <= 2'd0;
      end
    end else begin
      for (int j = 0; j < 4; j++) begin
        r_rd_pend[j] <= 1'b0;
        if (w_gnt_vld[j]) begin
          if (w_s_ack[j]) begin
            r_ptr[j]    <= w_gnt[j] + 2'd1;
            r_locked[j] <= 1'b0;
            if (!w_m_cmd[w_gnt[j]]) begin
              r_rd_pend[j] <= 1'b1;
              r_rd_src[j]  <= w_gnt[j];
            end
          end else begin
            r_locked[j] <= 1'b1;
            r_owner[j]  <= w_gnt[j];
          end
        end else begin
          r_locked[j] <= 1'b0;
        end
      end
    end
  end

  assign master_1_ack   = w_m_ack[0];
  assign master_2_ack   = w_m_ack[1];
  assign master_3_ack   = w_m_ack[2];
  assign master_4_ack   = w_m_ack[3];
  assign master_1_rdata = w_m_rdata[0];
  assign master_2_rdata = w_m_rdata[1];
  assign master_3_rdata = w_m_rdata[2];
  assign master_4_rdata = w_m_rdata[3];
  assign slave_1_req    = w_s_req[0];
  assign slave_2_req    = w_s_req[1];
  assign slave_3_req    = w_s_req[2];
  assign slave_4_req    = w_s_req[3];
  assign slave_1_addr   = w_s_addr[0];
  assign slave_2_addr   = w_s_addr[1];
  assign slave_3_addr   = w_s_addr[2];
  assign slave_4_addr   = w_s_addr[3];
  assign slave_1_cmd    = w_s_cmd[0];
  assign slave_2_cmd    = w_s_cmd[1];
  assign slave_3_cmd    = w_s_cmd[2];
  assign slave_4_cmd    = w_s_cmd[3];
  assign slave_1_wdata  = w_s_wdata[0];
  assign slave_2_wdata  = w_s_wdata[1];
  assign slave_3_wdata  = w_s_wdata[2];
  assign slave_4_wdata  = w_s_wdata[3];

endmodule

// File: tb/tb_crossbar_4x4.sv
// Directed bench for crossbar_4x4: inputs change after the falling edge,
// outputs are sampled 1 ns later, well away from the rising edge.
module tb_crossbar_4x4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        master_1_req, master_2_req, master_3_req, master_4_req;
  logic [31:0] master_1_addr, master_2_addr, master_3_addr, master_4_addr;
  logic        master_1_cmd, master_2_cmd, master_3_cmd, master_4_cmd;
  logic [31:0] master_1_wdata, master_2_wdata, master_3_wdata, master_4_wdata;
  logic        master_1_ack, master_2_ack, master_3_ack, master_4_ack;
  logic [31:0] master_1_rdata, master_2_rdata, master_3_rdata, master_4_rdata;
  logic        slave_1_req, slave_2_req, slave_3_req, slave_4_req;
  logic [31:0] slave_1_addr, slave_2_addr, slave_3_addr, slave_4_addr;
  logic        slave_1_cmd, slave_2_cmd, slave_3_cmd, slave_4_cmd;
  logic [31:0] slave_1_wdata, slave_2_wdata, slave_3_wdata, slave_4_wdata;
  logic        slave_1_ack, slave_2_ack, slave_3_ack, slave_4_ack;
  logic [31:0] slave_1_rdata, slave_2_rdata, slave_3_rdata, slave_4_rdata;

  logic [3:0] ack_v, sreq_v;
  assign ack_v  = {master_4_ack, master_3_ack, master_2_ack, master_1_ack};
  assign sreq_v = {slave_4_req, slave_3_req, slave_2_req, slave_1_req};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  crossbar_4x4 #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .master_1_req(master_1_req), .master_1_addr(master_1_addr), .master_1_cmd(master_1_cmd),
    .master_1_wdata(master_1_wdata), .master_1_ack(master_1_ack), .master_1_rdata(master_1_rdata),
    .master_2_req(master_2_req), .master_2_addr(master_2_addr), .master_2_cmd(master_2_cmd),
    .master_2_wdata(master_2_wdata), .master_2_ack(master_2_ack), .master_2_rdata(master_2_rdata),
    .master_3_req(master_3_req), .master_3_addr(master_3_addr), .master_3_cmd(master_3_cmd),
    .master_3_wdata(master_3_wdata), .master_3_ack(master_3_ack), .master_3_rdata(master_3_rdata),
    .master_4_req(master_4_req), .master_4_addr(master_4_addr), .master_4_cmd(master_4_cmd),
    .master_4_wdata(master_4_wdata), .master_4_ack(master_4_ack), .master_4_rdata(master_4_rdata),
    .slave_1_req(slave_1_req), .slave_1_addr(slave_1_addr), .slave_1_cmd(slave_1_cmd),
    .slave_1_wdata(slave_1_wdata), .slave_1_ack(slave_1_ack), .slave_1_rdata(slave_1_rdata),
    .slave_2_req(slave_2_req), .slave_2_addr(slave_2_addr), .slave_2_cmd(slave_2_cmd),
    .slave_2_wdata(slave_2_wdata), .slave_2_ack(slave_2_ack), .slave_2_rdata(slave_2_rdata),
    .slave_3_req(slave_3_req), .slave_3_addr(slave_3_addr), .slave_3_cmd(slave_3_cmd),
    .slave_3_wdata(slave_3_wdata), .slave_3_ack(slave_3_ack), .slave_3_rdata(slave_3_rdata),
    .slave_4_req(slave_4_req), .slave_4_addr(slave_4_addr), .slave_4_cmd(slave_4_cmd),
    .slave_4_wdata(slave_4_wdata), .slave_4_ack(slave_4_ack), .slave_4_rdata(slave_4_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_all();
    master_1_req = 0; master_1_addr = 0; master_1_cmd = 0; master_1_wdata = 0;
    master_2_req = 0; master_2_addr = 0; master_2_cmd = 0; master_2_wdata = 0;
    master_3_req = 0; master_3_addr = 0; master_3_cmd = 0; master_3_wdata = 0;
    master_4_req = 0; master_4_addr = 0; master_4_cmd = 0; master_4_wdata = 0;
    slave_1_ack = 0; slave_2_ack = 0; slave_3_ack = 0; slave_4_ack = 0;
    slave_1_rdata = 0; slave_2_rdata = 0; slave_3_rdata = 0; slave_4_rdata = 0;
  endtask

  initial begin
    // Reset: outputs forced low even with a live request and ack.
    reset_n = 1'b0;
    idle_all();
    master_1_req = 1; master_1_cmd = 1; slave_1_ack = 1;
    #1;
    chk("rst_sreq", 32'(sreq_v), 32'h0);
    chk("rst_ack", 32'(ack_v), 32'h0);
    chk("rst_m1_rdata", master_1_rdata, 32'h0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    idle_all();

    // 1: master 1 write to slave 1, immediate ack.
    @(negedge clk);
    master_1_req = 1; master_1_addr = 32'h0000_0010; master_1_cmd = 1; master_1_wdata = 32'h1234;
    slave_1_ack = 1;
    #1;
    chk("t1_sreq", 32'(sreq_v), 32'h1);
    chk("t1_s1_addr", slave_1_addr, 32'h10);
    chk("t1_s1_wdata", slave_1_wdata, 32'h1234);
    chk("t1_s1_cmd", 32'(slave_1_cmd), 32'h1);
    chk("t1_ack", 32'(ack_v), 32'h1);
    @(negedge clk);
    idle_all();
    slave_1_rdata = 32'h5555;
    #1;
    chk("t1_no_wr_rdata", master_1_rdata, 32'h0);

    // 2: master 2 read from slave 2; data only in the cycle after the ack.
    @(negedge clk);
    idle_all();
    master_2_req = 1; master_2_addr = 32'h4000_0008; master_2_cmd = 0;
    slave_2_ack = 1; slave_2_rdata = 32'hCAFE;
    #1;
    chk("t2_sreq", 32'(sreq_v), 32'h2);
    chk("t2_s2_addr", slave_2_addr, 32'h4000_0008);
    chk("t2_ack", 32'(ack_v), 32'h2);
    chk("t2_rdata_early", master_2_rdata, 32'h0);
    @(negedge clk);
    master_2_req = 0; slave_2_ack = 0;
    #1;
    chk("t2_rdata", master_2_rdata, 32'hCAFE);
    chk("t2_m1_rdata", master_1_rdata, 32'h0);
    @(negedge clk);
    #1;
    chk("t2_rdata_late", master_2_rdata, 32'h0);

    // 3: all masters hammer slave 3, acks rotate 1,2,3,4,1.
    @(negedge clk);
    idle_all();
    master_1_req = 1; master_1_addr = 32'h8000_0010; master_1_cmd = 1;
    master_2_req = 1; master_2_addr = 32'h8000_0020; master_2_cmd = 1;
    master_3_req = 1; master_3_addr = 32'h8000_0030; master_3_cmd = 1;
    master_4_req = 1; master_4_addr = 32'h8000_0040; master_4_cmd = 1;
    slave_3_ack = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("t3_ack_%0d", i), 32'(ack_v), 32'(1) << (i % 4));
      chk($sformatf("t3_addr_%0d", i), slave_3_addr, 32'h8000_0000 + 32'(((i % 4) + 1) * 16));
      chk($sformatf("t3_sreq_%0d", i), 32'(sreq_v), 32'h4);
      @(negedge clk);
    end

    // 4: masters 1..4 to slaves 4..1 concurrently.
    idle_all();
    master_1_req = 1; master_1_addr = 32'hC000_0004; master_1_cmd = 1; master_1_wdata = 32'h11;
    master_2_req = 1; master_2_addr = 32'h8000_0008; master_2_cmd = 1; master_2_wdata = 32'h22;
    master_3_req = 1; master_3_addr = 32'h4000_000C; master_3_cmd = 1; master_3_wdata = 32'h33;
    master_4_req = 1; master_4_addr = 32'h0000_0010; master_4_cmd = 1; master_4_wdata = 32'h44;
    slave_1_ack = 1; slave_2_ack = 1; slave_3_ack = 1; slave_4_ack = 1;
    #1;
    chk("t4_ack", 32'(ack_v), 32'hF);
    chk("t4_s4_addr", slave_4_addr, 32'hC000_0004);
    chk("t4_s4_wdata", slave_4_wdata, 32'h11);
    chk("t4_s3_wdata", slave_3_wdata, 32'h22);
    chk("t4_s2_addr", slave_2_addr, 32'h4000_000C);
    chk("t4_s1_wdata", slave_1_wdata, 32'h44);

    // 5: slave 1 pointer is back at master 1; master 3 takes the grant
    // first and must keep it while master 1 waits.
    @(negedge clk);
    idle_all();
    master_3_req = 1; master_3_addr = 32'h0000_0300; master_3_cmd = 1; master_3_wdata = 32'h333;
    #1;
    chk("t5_c0_addr", slave_1_addr, 32'h300);
    chk("t5_c0_ack", 32'(ack_v), 32'h0);
    @(negedge clk);
    master_1_req = 1; master_1_addr = 32'h0000_0100; master_1_cmd = 1; master_1_wdata = 32'h111;
    #1;
    chk("t5_c1_addr", slave_1_addr, 32'h300);
    @(negedge clk);
    #1;
    chk("t5_c2_wdata", slave_1_wdata, 32'h333);
    chk("t5_c2_ack", 32'(ack_v), 32'h0);
    @(negedge clk);
    slave_1_ack = 1;
    #1;
    chk("t5_m3_ack", 32'(ack_v), 32'h4);
    @(negedge clk);
    master_3_req = 0;
    #1;
    chk("t5_m1_ack", 32'(ack_v), 32'h1);
    chk("t5_m1_addr", slave_1_addr, 32'h100);

    // 6: read ack, then reset the next cycle; pending data must vanish and
    // slave 1 priority must restart at master 1 (it would be master 2).
    @(negedge clk);
    idle_all();
    master_1_req = 1; master_1_addr = 32'hC000_0020; master_1_cmd = 0;
    slave_4_ack = 1; slave_4_rdata = 32'hBEEF;
    #1;
    chk("t6_rd_ack", 32'(ack_v), 32'h1);
    @(negedge clk);
    reset_n = 1'b0;
    master_1_req = 0; slave_4_ack = 0;
    master_2_req = 1; master_2_addr = 32'h0000_0200; master_2_cmd = 1;
    slave_1_ack = 1;
    #1;
    chk("t6_rst_rdata", master_1_rdata, 32'h0);
    chk("t6_rst_sreq", 32'(sreq_v), 32'h0);
    chk("t6_rst_ack", 32'(ack_v), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    master_1_req = 1; master_1_addr = 32'h0000_0100; master_1_cmd = 1;
    master_3_req = 1; master_3_addr = 32'h0000_0300; master_3_cmd = 1;
    master_4_req = 1; master_4_addr = 32'h0000_0400; master_4_cmd = 1;
    #1;
    chk("t6_prio_ack", 32'(ack_v), 32'h1);
    chk("t6_post_rdata", master_1_rdata, 32'h0);
    @(negedge clk);
    idle_all();
    slave_4_rdata = 32'hBEEF;
    #1;
    chk("t6_post2_rdata", master_1_rdata, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/crossbar_4x4.md
Name: crossbar_4x4

Overview:
- Combinational-path 4-master × 4-slave interconnect with per-slave round-robin arbitration.
- Each master request is routed to one slave, selected by address bits [31:30].
- Acks route back to the requesting master; read data routes back one cycle after the ack.
- Sits between four bus masters and four memory-like slaves that use the same req/ack protocol.

Parameters:
- ADDR_W, 32, address width; bits [ADDR_W-1:ADDR_W-2] select the slave.
- DATA_W, 32, write/read data width.

Ports:
- clk  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- master_i_req  in  1  (i=1..4) transaction request from master i.
- master_i_addr  in  ADDR_W  request address.
- master_i_cmd  in  1  0 = read, 1 = write.
- master_i_wdata  in  DATA_W  write data, valid in the same cycle as the address.
- master_i_ack  out  1  request accepted this cycle.
- master_i_rdata  out  DATA_W  read data, valid the cycle after a read ack.
- slave_j_req  out  1  (j=1..4) request forwarded to slave j.
- slave_j_addr  out  ADDR_W  forwarded address, unmodified.
- slave_j_cmd  out  1  forwarded command.
- slave_j_wdata  out  DATA_W  forwarded write data.
- slave_j_ack  in  1  slave j accepts the presented request this cycle.
- slave_j_rdata  in  DATA_W  slave j read data, valid the cycle after its read ack.

Behaviour:
- Decode: master i targets slave j = addr[31:30]+1 (00→slave 1, …, 11→slave 4).
- Master protocol: a master holds req, addr, cmd and wdata stable until it sees ack. Each master has at most one outstanding request.
- Per-slave arbiter, round-robin:
  - Priority starts at the master after the last one acknowledged.
  - After reset, master 1 has highest priority.
- Grant lock: once master m is granted at slave j while slave_j_ack=0, the grant stays with m until slave_j_ack=1. A higher-priority late arrival must not preempt it.
- Request path (combinational, same cycle):
  - slave_j_req = 1 iff a granted master is requesting.
  - slave_j_addr/cmd/wdata mirror the granted master.
  - Idle slave outputs are all zero.
- Ack path (combinational): master_m_ack = slave_j_ack & (grant_j == m) & master_m_req.
- On a slave ack:
  - The pointer advances to (m mod 4)+1.
  - The lock clears.
  - If cmd=0, the crossbar registers rd_pend_j=1 and rd_src_j=m for exactly one cycle.
- Read return, cycle after ack: master_m_rdata = slave_j_rdata for the j with rd_pend_j & rd_src_j==m. Otherwise master_m_rdata = 0.
- Write acks produce no rdata response.
- Simultaneous events:
  - Different masters targeting different slaves are served in the same cycle (up to 4 transfers per cycle).
  - Back-to-back reads by one master to different slaves return in consecutive cycles, each routed by its own registered tag.
- Unrequested slaves never see req=1.
- Reset (async, reset_n=0):
  - Pointers → master 1.
  - Locks and rd_pend cleared.
  - All slave_* outputs and master_ack/rdata forced to 0 while reset_n=0.
  - Reset mid-transaction discards pending reads; no rdata appears after release.
- Latency: request to slave is 0 cycles; ack to master is 0 cycles; read data is 1 cycle after ack.

Test Plan:
1. Master 1 writes addr=0x0000_0010, wdata=0x1234, slave 1 acks immediately -> slave_1_req=1, slave_1_addr=0x10, slave_1_wdata=0x1234, master_1_ack=1 in the same cycle. No other slave_req is asserted.
2. Master 2 reads addr=0x4000_0008; slave 2 acks and drives rdata=0xCAFE next cycle -> master_2_rdata=0xCAFE in that cycle only; master_2_rdata=0 elsewhere.
3. All four masters request slave 3 (addr[31:30]=10) continuously, slave acks every cycle -> acks go to masters 1,2,3,4,1,… in order.
4. Masters 1–4 target slaves 4,3,2,1 simultaneously, all slaves ack -> all four master acks are 1 in the same cycle, with correct addr/wdata on each slave.
5. Master 3 is granted at slave 1 and slave_1_ack is held 0 for 3 cycles while master 1 raises req -> grant stays with master 3. Master 3 is acked first; master 1 is acked next.
6. Assert reset_n=0 the cycle after a read ack -> master rdata=0, all slave_req=0. After release, master 1 has top priority.
